// File: rtl/mem_block_reader.sv
// Block reader for the dual-port pixel memory: reads even/odd pixel pairs through ports a/b
// and streams them through a 4-entry FIFO. Optional macro MEM_BLOCK_READER_ROW_END_EN adds out_row_end.
module mem_block_reader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 12,
  parameter int CWIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [AWIDTH-1:0]   cfg_base,
  input  logic [CWIDTH-1:0]   cfg_pairs,
  input  logic [CWIDTH-1:0]   cfg_rows,
  input  logic [CWIDTH-1:0]   cfg_stride,
  output logic                busy,
  output logic                done,
  output logic [AWIDTH-1:0]   mem_address_a,
  output logic [AWIDTH-1:0]   mem_address_b,
  output logic                mem_wren_a,
  output logic                mem_wren_b,
  output logic [DWIDTH-1:0]   mem_data_a,
  output logic [DWIDTH-1:0]   mem_data_b,
  input  logic [DWIDTH-1:0]   mem_q_a,
  input  logic [DWIDTH-1:0]   mem_q_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DWIDTH-1:0] out_data,
`ifdef MEM_BLOCK_READER_ROW_END_EN
  output logic                out_row_end,
`endif
  output logic                out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [CWIDTH-1:0]   pairs_q, rows_q, stride_q;
  logic [CWIDTH-1:0]   col, row;
  logic [AWIDTH-1:0]   row_base, pair_addr;
  logic                cfg_empty, row_wrap, last_pair, issue;
  logic                addr_valid, addr_last, inflight, inflight_last;
  logic [2*DWIDTH-1:0] fifo_data [4];
  logic                fifo_last [4];
  logic [1:0]          wr_ptr, rd_ptr;
  logic [2:0]          count, occupancy;
  logic                push, pop;
`ifdef MEM_BLOCK_READER_ROW_END_EN
  logic                addr_row_end, inflight_row_end;
  logic                fifo_row_end [4];
`endif

  assign mem_wren_a = 1'b0;
  assign mem_wren_b = 1'b0;
  assign mem_data_a = '0;
  assign mem_data_b = '0;

  always_comb begin
    cfg_empty = (cfg_pairs == '0) || (cfg_rows == '0);
    row_wrap  = (col == pairs_q - CWIDTH'(1));
    last_pair = row_wrap && (row == rows_q - CWIDTH'(1));
    pair_addr = row_base + (AWIDTH'(col) << 1);
    // A read is in the air for two cycles (address register, then memory
    // output register), so both stages hold a FIFO credit.
    occupancy = count + 3'(addr_valid) + 3'(inflight);
    issue     = (state == ISSUE) && (occupancy < 3'd4);
    out_valid = (count != 3'd0);
    pop       = out_valid && out_ready;
    push      = inflight;
    out_data  = fifo_data[rd_ptr];
    out_last  = fifo_last[rd_ptr];
`ifdef MEM_BLOCK_READER_ROW_END_EN
    out_row_end = fifo_row_end[rd_ptr];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = cfg_empty ? DONE : ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (issue && last_pair) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!addr_valid && !inflight && (count == 3'd0)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pairs_q       <= '0;
      rows_q        <= '0;
      stride_q      <= '0;
      col           <= '0;
      row           <= '0;
      row_base      <= '0;
      mem_address_a <= '0;
      mem_address_b <= '0;
      addr_valid    <= 1'b0;
      addr_last     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
`ifdef MEM_BLOCK_READER_ROW_END_EN
      addr_row_end     <= 1'b0;
      inflight_row_end <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) fifo_row_end[i] <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        pairs_q  <= cfg_pairs;
        rows_q   <= cfg_rows;
        stride_q <= cfg_stride;
        col      <= '0;
        row      <= '0;
        row_base <= cfg_base;
      end

      if (issue) begin
        mem_address_a <= pair_addr;
        mem_address_b <= pair_addr + AWIDTH'(1);
        if (row_wrap) begin
          col      <= '0;
          row      <= row + CWIDTH'(1);
          row_base <= row_base + AWIDTH'(stride_q);
        end else begin
          col <= col + CWIDTH'(1);
        end
      end

      addr_valid    <= issue;
      addr_last     <= issue && last_pair;
      inflight      <= addr_valid;
      inflight_last <= addr_last;
`ifdef MEM_BLOCK_READER_ROW_END_EN
      addr_row_end     <= issue && row_wrap;
      inflight_row_end <= addr_row_end;
`endif

      if (push) begin
        fifo_data[wr_ptr] <= {mem_q_b, mem_q_a};
        fifo_last[wr_ptr] <= inflight_last;
`ifdef MEM_BLOCK_READER_ROW_END_EN
        fifo_row_end[wr_ptr] <= inflight_row_end;
`endif
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

endmodule
